link_training_seq: RTL and testbench

Sequences DisplayPort link training: the clock-recovery (CR) phase first, then the channel-equalization (EQ) phase. Pulses the start inputs of the link-training wait counter and waits for its fire outputs. Issues lane-set writes and lane-status reads over an abstracted AUX request/ack handshake. Applies the receiver's drive-adjust requests and reports pass or fail to the top-level link policy logic.

---
 rtl/lt_seq_pkg.sv | 39 +++
 rtl/lt_lane_eval.sv | 39 +++
 rtl/link_training_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_link_training_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lt_seq_pkg.sv
// rtl/lt_seq_pkg.sv - shared types, codes and lane-mask helper for the link-training sequencer
package lt_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CR_WR,
    ST_CR_WAIT,
    ST_CR_RD,
    ST_CR_CHK,
    ST_EQ_WR,
    ST_EQ_WAIT,
    ST_EQ_RD,
    ST_EQ_CHK,
    ST_DONE,
    ST_FAIL
  } lt_state_t;

  localparam logic [1:0] TPS_NONE   = 2'd0;
  localparam logic [1:0] TPS1       = 2'd1;
  localparam logic [1:0] TPS2       = 2'd2;

  localparam logic       AUX_OP_WR  = 1'b0;
  localparam logic       AUX_OP_RD  = 1'b1;

  localparam logic [1:0] VSWING_MAX = 2'd3;

  // Lane 'lane' takes part in training for the given lane_cnt; any count
  // other than 1 or 2 means the full four-lane link.
  function automatic logic lane_mask(input logic [2:0] lane_cnt, input int lane);
    int active;
    case (lane_cnt)
      3'd1:    active = 1;
      3'd2:    active = 2;
      default: active = 4;
    endcase
    return (lane < active);
  endfunction

endpackage

// File: rtl/lt_lane_eval.sv
// rtl/lt_lane_eval.sv - combinational per-lane status reduction for link training
module lt_lane_eval
  import lt_seq_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic [2:0]             lane_cnt,
  input  logic [NUM_LANES-1:0]   cr_done,
  input  logic [NUM_LANES-1:0]   eq_done,
  input  logic [NUM_LANES-1:0]   sym_lock,
  input  logic [2*NUM_LANES-1:0] vswing,
  input  logic [2*NUM_LANES-1:0] adj_vswing,
  output logic                   all_cr_done,
  output logic                   all_eq_ok,
  output logic                   any_max_swing,
  output logic                   adj_same
);

  // Reduce only the active lanes; inactive lanes can report anything.
  always_comb begin
    all_cr_done   = 1'b1;
    all_eq_ok     = 1'b1;
    any_max_swing = 1'b0;
    adj_same      = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_mask(lane_cnt, i)) begin
        if (!cr_done[i])
          all_cr_done = 1'b0;
        if (!(eq_done[i] && sym_lock[i]))
          all_eq_ok = 1'b0;
        if (vswing[2*i +: 2] == VSWING_MAX)
          any_max_swing = 1'b1;
        if (adj_vswing[2*i +: 2] != vswing[2*i +: 2])
          adj_same = 1'b0;
      end
    end
  end

endmodule

// File: rtl/link_training_seq.sv
// rtl/link_training_seq.sv - DisplayPort CR/EQ link-training sequencer; optional AUX watchdog via LT_AUX_TIMEOUT_EN
module link_training_seq
  import lt_seq_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int MAX_CR_SAME  = 5,
  parameter int MAX_EQ_LOOPS = 5,
  parameter int AUX_TIMEOUT  = 2000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lt_start,
  input  logic                   lt_abort,
  input  logic [2:0]             lane_cnt,
  input  logic [7:0]             rd_interval,
  output logic                   cr_ctr_start,
  output logic                   eq_ctr_start,
  output logic [7:0]             eq_rd_value,
  input  logic                   cr_ctr_fire,
  input  logic                   eq_ctr_fire,
  output logic                   aux_req,
  output logic                   aux_op,
  input  logic                   aux_ack,
  input  logic [NUM_LANES-1:0]   st_cr_done,
  input  logic [NUM_LANES-1:0]   st_eq_done,
  input  logic [NUM_LANES-1:0]   st_sym_lock,
  input  logic [2*NUM_LANES-1:0] adj_vswing,
  input  logic [2*NUM_LANES-1:0] adj_preemph,
  output logic [1:0]             tps_sel,
  output logic [2*NUM_LANES-1:0] vswing,
  output logic [2*NUM_LANES-1:0] preemph,
  output logic                   lt_busy,
  output logic                   lt_done,
  output logic                   lt_fail
);

  localparam logic [2:0] CR_SAME_LIM = 3'(MAX_CR_SAME);
  localparam logic [2:0] EQ_LOOP_LIM = 3'(MAX_EQ_LOOPS);

  lt_state_t              state;
  logic                   lt_start_d;
  logic [2:0]             same_cnt;
  logic [2:0]             eq_cnt;
  logic [NUM_LANES-1:0]   cr_done_q;
  logic [NUM_LANES-1:0]   eq_done_q;
  logic [NUM_LANES-1:0]   sym_lock_q;
  logic [2*NUM_LANES-1:0] adj_v_q;
  logic [2*NUM_LANES-1:0] adj_p_q;

  logic                   start_rise;
  logic [2:0]             same_inc;
  logic [2:0]             eq_inc;
  logic                   all_cr_done;
  logic                   all_eq_ok;
  logic                   any_max_swing;
  logic                   adj_same;
  logic                   wd_expire;

  assign start_rise = lt_start && !lt_start_d;
  assign same_inc   = (same_cnt == 3'd7) ? same_cnt : same_cnt + 3'd1;
  assign eq_inc     = (eq_cnt == 3'd7) ? eq_cnt : eq_cnt + 3'd1;

  lt_lane_eval #(
    .NUM_LANES (NUM_LANES)
  ) u_lane_eval (
    .lane_cnt      (lane_cnt),
    .cr_done       (cr_done_q),
    .eq_done       (eq_done_q),
    .sym_lock      (sym_lock_q),
    .vswing        (vswing),
    .adj_vswing    (adj_v_q),
    .all_cr_done   (all_cr_done),
    .all_eq_ok     (all_eq_ok),
    .any_max_swing (any_max_swing),
    .adj_same      (adj_same)
  );

`ifdef LT_AUX_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign wd_expire = aux_req && !aux_ack && (wd_cnt == 16'(AUX_TIMEOUT - 1));

  // Count cycles of an outstanding AUX request; any ack or idle bus clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wd_cnt <= '0;
    else if (aux_req && !aux_ack && !wd_expire)
      wd_cnt <= wd_cnt + 16'd1;
    else
      wd_cnt <= '0;
  end
`else
  logic [15:0] unused_aux_timeout;

  assign unused_aux_timeout = 16'(AUX_TIMEOUT);
  assign wd_expire          = 1'b0;
`endif

  // Training sequencer: CR loop, then EQ loop, with abort and watchdog overrides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      lt_start_d   <= 1'b0;
      same_cnt     <= '0;
      eq_cnt       <= '0;
      cr_done_q    <= '0;
      eq_done_q    <= '0;
      sym_lock_q   <= '0;
      adj_v_q      <= '0;
      adj_p_q      <= '0;
      cr_ctr_start <= 1'b0;
      eq_ctr_start <= 1'b0;
      eq_rd_value  <= '0;
      aux_req      <= 1'b0;
      aux_op       <= AUX_OP_WR;
      tps_sel      <= TPS_NONE;
      vswing       <= '0;
      preemph      <= '0;
      lt_busy      <= 1'b0;
      lt_done      <= 1'b0;
      lt_fail      <= 1'b0;
    end else begin
      lt_start_d   <= lt_start;
      cr_ctr_start <= 1'b0;
      eq_ctr_start <= 1'b0;
      if (lt_abort) begin
        state   <= ST_IDLE;
        tps_sel <= TPS_NONE;
        aux_req <= 1'b0;
        aux_op  <= AUX_OP_WR;
        lt_busy <= 1'b0;
        lt_done <= 1'b0;
        lt_fail <= 1'b0;
      end else if (wd_expire) begin
        state   <= ST_FAIL;
        tps_sel <= TPS_NONE;
        aux_req <= 1'b0;
        lt_busy <= 1'b0;
        lt_fail <= 1'b1;
      end else begin
        case (state)
          ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start_rise) begin
              vswing      <= '0;
              preemph     <= '0;
              same_cnt    <= '0;
              eq_cnt      <= '0;
              tps_sel     <= TPS1;
              eq_rd_value <= rd_interval;
              aux_req     <= 1'b1;
              aux_op      <= AUX_OP_WR;
              lt_busy     <= 1'b1;
              lt_done     <= 1'b0;
              lt_fail     <= 1'b0;
              state       <= ST_CR_WR;
            end
          end
          ST_CR_WR: begin
            if (aux_ack) begin
              aux_req      <= 1'b0;
              cr_ctr_start <= 1'b1;
              state        <= ST_CR_WAIT;
            end
          end
          ST_CR_WAIT: begin
            if (cr_ctr_fire) begin
              aux_req <= 1'b1;
              aux_op  <= AUX_OP_RD;
              state   <= ST_CR_RD;
            end
          end
          ST_CR_RD, ST_EQ_RD: begin
            if (aux_ack) begin
              aux_req    <= 1'b0;
              cr_done_q  <= st_cr_done;
              eq_done_q  <= st_eq_done;
              sym_lock_q <= st_sym_lock;
              adj_v_q    <= adj_vswing;
              adj_p_q    <= adj_preemph;
              state      <= (state == ST_CR_RD) ? ST_CR_CHK : ST_EQ_CHK;
            end
          end
          ST_CR_CHK: begin
            if (all_cr_done) begin
              tps_sel <= TPS2;
              eq_cnt  <= '0;
              aux_req <= 1'b1;
              aux_op  <= AUX_OP_WR;
              state   <= ST_EQ_WR;
            end else if (any_max_swing || (adj_same && same_inc >= CR_SAME_LIM)) begin
              state   <= ST_FAIL;
              tps_sel <= TPS_NONE;
              lt_busy <= 1'b0;
              lt_fail <= 1'b1;
            end else begin
              same_cnt <= adj_same ? same_inc : 3'd0;
              vswing   <= adj_v_q;
              preemph  <= adj_p_q;
              aux_req  <= 1'b1;
              aux_op   <= AUX_OP_WR;
              state    <= ST_CR_WR;
            end
          end
          ST_EQ_WR: begin
            if (aux_ack) begin
              aux_req      <= 1'b0;
              eq_ctr_start <= 1'b1;
              state        <= ST_EQ_WAIT;
            end
          end
          ST_EQ_WAIT: begin
            if (eq_ctr_fire) begin
              aux_req <= 1'b1;
              aux_op  <= AUX_OP_RD;
              state   <= ST_EQ_RD;
            end
          end
          ST_EQ_CHK: begin
            if (!all_cr_done || (!all_eq_ok && eq_inc == EQ_LOOP_LIM)) begin
              state   <= ST_FAIL;
              tps_sel <= TPS_NONE;
              lt_busy <= 1'b0;
              lt_fail <= 1'b1;
            end else if (all_eq_ok) begin
              state   <= ST_DONE;
              tps_sel <= TPS_NONE;
              lt_busy <= 1'b0;
              lt_done <= 1'b1;
            end else begin
              eq_cnt  <= eq_inc;
              vswing  <= adj_v_q;
              preemph <= adj_p_q;
              aux_req <= 1'b1;
              aux_op  <= AUX_OP_WR;
              state   <= ST_EQ_WR;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_link_training_seq.sv
// tb/tb_link_training_seq.sv - randomized sink/counter bench with transaction-level reference model
module tb_link_training_seq;

  localparam int AUX_TIMEOUT = 2000;
  localparam int SL          = 32;

  logic       clk, rst_n, lt_start, lt_abort;
  logic [2:0] lane_cnt;
  logic [7:0] rd_interval, eq_rd_value;
  logic       cr_ctr_start, eq_ctr_start, cr_ctr_fire, eq_ctr_fire;
  logic       aux_req, aux_op, aux_ack;
  logic [3:0] st_cr_done, st_eq_done, st_sym_lock;
  logic [7:0] adj_vswing, adj_preemph, vswing, preemph;
  logic [1:0] tps_sel;
  logic       lt_busy, lt_done, lt_fail;

  link_training_seq #(
    .NUM_LANES(4), .MAX_CR_SAME(5), .MAX_EQ_LOOPS(5), .AUX_TIMEOUT(AUX_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lt_start(lt_start), .lt_abort(lt_abort),
    .lane_cnt(lane_cnt), .rd_interval(rd_interval),
    .cr_ctr_start(cr_ctr_start), .eq_ctr_start(eq_ctr_start), .eq_rd_value(eq_rd_value),
    .cr_ctr_fire(cr_ctr_fire), .eq_ctr_fire(eq_ctr_fire),
    .aux_req(aux_req), .aux_op(aux_op), .aux_ack(aux_ack),
    .st_cr_done(st_cr_done), .st_eq_done(st_eq_done), .st_sym_lock(st_sym_lock),
    .adj_vswing(adj_vswing), .adj_preemph(adj_preemph),
    .tps_sel(tps_sel), .vswing(vswing), .preemph(preemph),
    .lt_busy(lt_busy), .lt_done(lt_done), .lt_fail(lt_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Sink script: what the receiver reports on its k-th status read.
  logic [3:0] sc_cr [SL];
  logic [3:0] sc_eq [SL];
  logic [3:0] sc_lk [SL];
  logic [7:0] sc_av [SL];
  logic [7:0] sc_ap [SL];

  // Reference expectations.
  logic [7:0] exp_v [$];
  logic [7:0] exp_p [$];
  logic [1:0] exp_t [$];
  int         exp_ncr, exp_neq;
  bit         exp_done;
  logic [7:0] exp_fv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int nlanes(input logic [2:0] lc);
    return (lc == 3'd1) ? 1 : (lc == 3'd2) ? 2 : 4;
  endfunction

  function automatic bit all_set(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) if (!v[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit any_max(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) if (((v >> (2*i)) & 8'h3) == 8'h3) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit same_sw(input logic [7:0] a, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) if (((a >> (2*i)) & 8'h3) != ((b >> (2*i)) & 8'h3)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic fill_good();
    for (int i = 0; i < SL; i++) begin
      sc_cr[i] = 4'hF; sc_eq[i] = 4'hF; sc_lk[i] = 4'hF; sc_av[i] = 8'h00; sc_ap[i] = 8'h00;
    end
  endtask

  task automatic set_rd(input int i, input logic [3:0] c, input logic [3:0] e, input logic [3:0] l,
                        input logic [7:0] av, input logic [7:0] ap);
    sc_cr[i] = c; sc_eq[i] = e; sc_lk[i] = l; sc_av[i] = av; sc_ap[i] = ap;
  endtask

  // Transaction-level model: one iteration per lane-set write followed by one status read.
  task automatic model(input logic [2:0] lc);
    int n = nlanes(lc);
    logic [7:0] vs = 8'h00;
    logic [7:0] pe = 8'h00;
    int same = 0;
    int eqc = 0;
    bit eqph = 0;
    bit fin = 0;
    exp_v.delete(); exp_p.delete(); exp_t.delete();
    exp_ncr = 0; exp_neq = 0; exp_done = 0;
    for (int r = 0; r < SL && !fin; r++) begin
      exp_v.push_back(vs); exp_p.push_back(pe); exp_t.push_back(eqph ? 2'd2 : 2'd1);
      if (eqph) exp_neq++; else exp_ncr++;
      if (!eqph) begin
        if (all_set(sc_cr[r], n)) begin
          eqph = 1; eqc = 0;
        end else if (any_max(vs, n)) begin
          fin = 1; exp_done = 0;
        end else begin
          same = same_sw(sc_av[r], vs, n) ? same + 1 : 0;
          if (same >= 5) begin fin = 1; exp_done = 0; end
          else begin vs = sc_av[r]; pe = sc_ap[r]; end
        end
      end else begin
        if (!all_set(sc_cr[r], n)) begin
          fin = 1; exp_done = 0;
        end else if (all_set(sc_eq[r] & sc_lk[r], n)) begin
          fin = 1; exp_done = 1;
        end else begin
          eqc++;
          if (eqc == 5) begin fin = 1; exp_done = 0; end
          else begin vs = sc_av[r]; pe = sc_ap[r]; end
        end
      end
    end
    exp_fv = vs;
  endtask

  // Play the sink and the wait counter until the DUT reports done/fail, then score.
  task automatic run(input string tag, input logic [2:0] lc, input logic [7:0] iv);
    int ncr = 0, neq = 0, r = 0, lat = 0, crd = -1, eqd = -1;
    bit prev_s = 0, b2b = 0, fin = 0;
    logic [7:0] wv [$];
    logic [7:0] wp [$];
    logic [1:0] wt [$];
    model(lc);
    lane_cnt = lc; rd_interval = iv;
    @(negedge clk); lt_start = 1'b1;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      lt_start = 1'b0;
      if (cyc == 0) chk({tag, ".busy_after_start"}, lt_busy, 1);
      if ((cr_ctr_start || eq_ctr_start) && prev_s) b2b = 1;
      prev_s = cr_ctr_start || eq_ctr_start;
      cr_ctr_fire = 1'b0; eq_ctr_fire = 1'b0;
      if (crd == 0) begin cr_ctr_fire = 1'b1; crd = -1; end else if (crd > 0) crd--;
      if (eqd == 0) begin eq_ctr_fire = 1'b1; eqd = -1; end else if (eqd > 0) eqd--;
      if (cr_ctr_start) begin ncr++; crd = $urandom_range(0, 3); end
      if (eq_ctr_start) begin neq++; eqd = $urandom_range(0, 3); end
      if (aux_ack) aux_ack = 1'b0;
      else if (aux_req) begin
        if (lat > 0) lat--;
        else begin
          aux_ack = 1'b1; lat = $urandom_range(0, 2);
          if (aux_op == 1'b0) begin
            wv.push_back(vswing); wp.push_back(preemph); wt.push_back(tps_sel);
          end else begin
            if (r < SL) begin
              st_cr_done = sc_cr[r]; st_eq_done = sc_eq[r]; st_sym_lock = sc_lk[r];
              adj_vswing = sc_av[r]; adj_preemph = sc_ap[r];
            end else begin
              st_cr_done = 4'hF; st_eq_done = 4'hF; st_sym_lock = 4'hF;
              adj_vswing = 8'h00; adj_preemph = 8'h00;
            end
            r++;
          end
        end
      end
      if (!aux_ack) begin
        st_cr_done = 4'($urandom); st_eq_done = 4'($urandom); st_sym_lock = 4'($urandom);
        adj_vswing = 8'($urandom); adj_preemph = 8'($urandom);
      end
      if (lt_done || lt_fail) fin = 1;
    end
    cr_ctr_fire = 1'b0; eq_ctr_fire = 1'b0; aux_ack = 1'b0;
    chk({tag, ".finished"}, fin, 1);
    chk({tag, ".lt_done"}, lt_done, exp_done);
    chk({tag, ".lt_fail"}, lt_fail, !exp_done);
    chk({tag, ".cr_starts"}, ncr, exp_ncr);
    chk({tag, ".eq_starts"}, neq, exp_neq);
    chk({tag, ".writes"}, wv.size(), exp_v.size());
    for (int i = 0; i < wv.size() && i < exp_v.size(); i++) begin
      chk($sformatf("%s.wr%0d_vswing", tag, i), wv[i], exp_v[i]);
      chk($sformatf("%s.wr%0d_preemph", tag, i), wp[i], exp_p[i]);
      chk($sformatf("%s.wr%0d_tps", tag, i), wt[i], exp_t[i]);
    end
    chk({tag, ".final_vswing"}, vswing, exp_fv);
    chk({tag, ".tps_end"}, tps_sel, 0);
    chk({tag, ".busy_end"}, lt_busy, 0);
    chk({tag, ".aux_req_end"}, aux_req, 0);
    chk({tag, ".eq_rd_value"}, eq_rd_value, iv);
    chk({tag, ".pulse_gap"}, b2b, 0);
  endtask

  initial begin
    logic [2:0] lcs [7];
    int         quiet;
    lcs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    rst_n = 1'b0; lt_start = 1'b0; lt_abort = 1'b0; lane_cnt = 3'd4; rd_interval = 8'h00;
    cr_ctr_fire = 1'b0; eq_ctr_fire = 1'b0; aux_ack = 1'b0;
    st_cr_done = 4'h0; st_eq_done = 4'h0; st_sym_lock = 4'h0; adj_vswing = 8'h00; adj_preemph = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset.aux_req", aux_req, 0);
    chk("reset.starts", {cr_ctr_start, eq_ctr_start}, 0);
    chk("reset.tps_sel", tps_sel, 0);
    chk("reset.drive", {vswing, preemph}, 0);
    chk("reset.flags", {lt_busy, lt_done, lt_fail}, 0);
    chk("reset.eq_rd_value", eq_rd_value, 0);
    rst_n = 1'b1;
    @(negedge clk);

    fill_good();
    run("ideal", 3'd4, 8'h04);

    fill_good();
    set_rd(0, 4'h0, 4'h0, 4'h0, 8'h55, 8'h11);
    set_rd(1, 4'h0, 4'h0, 4'h0, 8'hAA, 8'h22);
    run("cr_adjust", 3'd4, 8'h10);

    fill_good();
    for (int i = 0; i < 8; i++) set_rd(i, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00);
    run("same_req", 3'd4, 8'h01);

    fill_good();
    for (int i = 1; i < 8; i++) set_rd(i, 4'hF, 4'h0, 4'hF, 8'h00, 8'h00);
    run("eq_exhaust", 3'd4, 8'h02);

    fill_good();
    set_rd(1, 4'hF, 4'h0, 4'h0, 8'h00, 8'h00);
    set_rd(2, 4'h0, 4'hF, 4'hF, 8'h00, 8'h00);
    run("cr_lost", 3'd2, 8'h03);

    fill_good();
    set_rd(0, 4'($urandom) | 4'h1, 4'($urandom), 4'($urandom), 8'($urandom) & 8'hFC, 8'($urandom));
    set_rd(1, 4'($urandom) | 4'h1, 4'($urandom) | 4'h1, 4'($urandom) | 4'h1, 8'($urandom), 8'($urandom));
    run("one_lane", 3'd1, 8'h20);

    for (int k = 0; k < 8; k++) begin
      fill_good();
      for (int i = 0; i < 6; i++) begin
        sc_cr[i] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
        sc_eq[i] = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
        sc_lk[i] = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
        sc_av[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        sc_ap[i] = 8'($urandom);
      end
      run($sformatf("rand%0d", k), lcs[$urandom_range(0, 6)], 8'($urandom));
    end

    // Abort while waiting on the CR counter; the late fire must not restart anything.
    lane_cnt = 3'd4;
    @(negedge clk); lt_start = 1'b1;
    @(negedge clk); lt_start = 1'b0;
    chk("abort.aux_req_wr", aux_req, 1);
    aux_ack = 1'b1;
    @(negedge clk); aux_ack = 1'b0;
    chk("abort.cr_start", cr_ctr_start, 1);
    lt_abort = 1'b1;
    @(negedge clk); lt_abort = 1'b0; cr_ctr_fire = 1'b1;
    chk("abort.busy", lt_busy, 0);
    @(negedge clk); cr_ctr_fire = 1'b0;
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (aux_req || lt_busy || cr_ctr_start) quiet++;
    end
    chk("abort.stays_idle", quiet, 0);
    chk("abort.tps_sel", tps_sel, 0);
    chk("abort.done_fail", {lt_done, lt_fail}, 0);

    // Start and abort together: abort wins.
    @(negedge clk); lt_start = 1'b1; lt_abort = 1'b1;
    @(negedge clk); lt_start = 1'b0; lt_abort = 1'b0;
    chk("start_abort.busy", lt_busy, 0);
    chk("start_abort.aux_req", aux_req, 0);
    repeat (2) @(negedge clk);

    fill_good();
    run("after_abort", 3'd4, 8'h7E);

`ifdef LT_AUX_TIMEOUT_EN
    begin
      int nreq = 0;
      lane_cnt = 3'd4;
      @(negedge clk); lt_start = 1'b1;
      @(negedge clk); lt_start = 1'b0;
      for (int cyc = 0; cyc < 3 * AUX_TIMEOUT && !lt_fail; cyc++) begin
        if (aux_req) nreq++;
        @(negedge clk);
      end
      chk("timeout.cycles", nreq, AUX_TIMEOUT);
      chk("timeout.lt_fail", lt_fail, 1);
      chk("timeout.aux_req", aux_req, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
